bcp_clause_feeder: RTL and testbench

//  Producer side of the bcp_check interface. Scans a clause memory, reads

---
 rtl/bcp_clause_feeder.sv | 214 +++++++++++++++++++++
 tb/tb_bcp_clause_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcp_clause_feeder.sv
// Clause feeder for the BCP checker: scans clause memory, packs literals against the
// current assignment, turns unit results into queued implications and flags conflicts.

module bcp_slot_pack #(
  parameter  int NUM_VARS = 16,
  localparam int VAR_W    = $clog2(NUM_VARS)
) (
  input  logic [VAR_W-1:0]    var_idx,
  input  logic                pol,
  input  logic                in_size,
  input  logic [NUM_VARS-1:0] asg_def,
  input  logic [NUM_VARS-1:0] asg_val,
  output logic                assigned,
  output logic                value
);
  // Unassigned and padding slots take ~pol so they can never read as a true literal.
  assign assigned = in_size ? asg_def[var_idx] : 1'b1;
  assign value    = (in_size && asg_def[var_idx]) ? asg_val[var_idx] : ~pol;
endmodule

module bcp_clause_feeder #(
  parameter  int NUM_VARS   = 16,
  parameter  int ADDR_W     = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int VAR_W      = $clog2(NUM_VARS),
  localparam int RD_W       = 6 + 4*VAR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     num_clauses,
  input  logic [NUM_VARS-1:0] asg_def,
  input  logic [NUM_VARS-1:0] asg_val,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [RD_W-1:0]     mem_rdata,
  output logic [7:0]          clause,
  output logic [7:0]          clause_type,
  output logic [3:0]          clause_odd,
  input  logic [3:0]          unit_clause,
  output logic                imp_valid,
  input  logic                imp_ready,
  output logic [VAR_W-1:0]    imp_var,
  output logic                imp_val,
  output logic                busy,
  output logic                done,
  output logic                conflict,
  output logic [ADDR_W-1:0]   conflict_clause
);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = CW + 2;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   nc_q;

  // vld_pipe[n] tags the clause sitting n cycles after its issue.
  logic [3:1]        vld_pipe;
  logic [ADDR_W-1:0] k1, k2, k3;
  logic [7:0]        clause2, type2;
  logic [3:0]        odd2, val2;
  logic [3:0][VAR_W-1:0] vars2, vars3;
  logic [3:0]        pol3;
  logic              conf3;

  logic [FIFO_DEPTH-1:0][VAR_W:0] fifo_q;
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     fifo_cnt;

  logic [3:0][VAR_W-1:0] rd_var;
  logic [3:0]        rd_pol, pk_odd, pk_val, in_size;
  logic [1:0]        rd_sz;
  logic [7:0]        pk_clause;
  logic [OCW-1:0]    occ;
  logic              issue, last_issue, conf_hit, conf_c, push, pop;
  logic [1:0]        uj;

  assign rd_var = mem_rdata[4*VAR_W-1:0];
  assign rd_pol = mem_rdata[4*VAR_W +: 4];
  assign rd_sz  = mem_rdata[RD_W-1 -: 2];

  for (genvar i = 0; i < 4; i++) begin : g_slot
    assign in_size[i] = (2'(i) <= rd_sz);
    bcp_slot_pack #(.NUM_VARS(NUM_VARS)) u_pack (
      .var_idx (rd_var[i]),
      .pol     (rd_pol[i]),
      .in_size (in_size[i]),
      .asg_def (asg_def),
      .asg_val (asg_val),
      .assigned(pk_odd[i]),
      .value   (pk_val[i])
    );
    assign pk_clause[2*i+1] = pk_odd[i];
    assign pk_clause[2*i]   = pk_val[i];
  end

  // Padding slots are assigned and false, so only real literals decide the conflict.
  assign conf_c   = (&odd2) && ((val2 ^ type2[3:0]) == 4'hF);
  assign conf_hit = vld_pipe[3] && conf3;
  assign push     = vld_pipe[3] && !conf3 && (unit_clause != 4'h0);
  assign imp_valid = (fifo_cnt != '0);
  assign pop      = imp_valid && imp_ready;

  // Every clause in flight may still push, so it holds a FIFO credit until it retires.
  assign occ   = OCW'(fifo_cnt) + OCW'(vld_pipe[1]) + OCW'(vld_pipe[2]) + OCW'(vld_pipe[3]);
  assign issue = (state_q == SCAN) && !conf_hit && (occ < OCW'(FIFO_DEPTH));
  assign last_issue = issue && ({1'b0, idx_q} == nc_q - (ADDR_W+1)'(1));

  always_comb begin
    uj = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (unit_clause[i]) uj = 2'(i);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_clauses == '0) ? DONE : SCAN;
      SCAN:    if (conf_hit) state_d = DONE;
               else if (last_issue) state_d = DRAIN;
      DRAIN:   if (conf_hit || (vld_pipe == '0 && fifo_cnt == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      nc_q            <= '0;
      conflict        <= 1'b0;
      conflict_clause <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        nc_q            <= num_clauses;
        idx_q           <= '0;
        conflict        <= 1'b0;
        conflict_clause <= '0;
      end else if (issue) begin
        idx_q <= idx_q + ADDR_W'(1);
      end
      if (conf_hit) begin
        conflict        <= 1'b1;
        conflict_clause <= k3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      k1 <= '0; k2 <= '0; k3 <= '0;
      clause2 <= '0; type2 <= 8'hC0; odd2 <= 4'hF; val2 <= '0;
      vars2 <= '0; vars3 <= '0; pol3 <= '0; conf3 <= 1'b0;
    end else begin
      vld_pipe <= conf_hit ? 3'b000 : {vld_pipe[2:1], issue};
      k1 <= idx_q;
      if (vld_pipe[1]) begin
        k2      <= k1;
        clause2 <= pk_clause;
        type2   <= {rd_sz, 2'b00, rd_pol};
        odd2    <= pk_odd;
        val2    <= pk_val;
        vars2   <= rd_var;
      end
      if (vld_pipe[2]) begin
        k3    <= k2;
        vars3 <= vars2;
        pol3  <= type2[3:0];
        conf3 <= conf_c;
      end
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || conf_hit) begin
      fifo_q   <= '0;
      wp       <= '0;
      rp       <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_q[wp] <= {vars3[uj], pol3[uj]};
        wp         <= ptr_inc(wp);
      end
      if (pop) rp <= ptr_inc(rp);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign mem_en      = issue;
  assign mem_addr    = idx_q;
  assign clause      = vld_pipe[2] ? clause2 : 8'h00;
  assign clause_type = vld_pipe[2] ? type2   : 8'hC0;
  assign clause_odd  = vld_pipe[2] ? odd2    : 4'hF;
  assign imp_var     = fifo_q[rp][VAR_W:1];
  assign imp_val     = fifo_q[rp][0];
  assign busy        = (state_q == SCAN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_bcp_clause_feeder.sv
// Directed bench for bcp_clause_feeder with a clause-memory model, a behavioural
// checker and an implication scoreboard.

module tb_bcp_clause_feeder;
  localparam int NV = 16, AW = 8, VW = 4, RW = 6 + 4*VW;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, imp_ready = 1'b1;
  logic [AW:0]   num_clauses = '0;
  logic [NV-1:0] asg_def = '0, asg_val = '0;
  logic          mem_en, imp_valid, imp_val, busy, done, conflict;
  logic [AW-1:0] mem_addr, conflict_clause;
  logic [RW-1:0] mem_rdata = '0;
  logic [7:0]    clause, clause_type;
  logic [3:0]    clause_odd, unit_clause = '0;
  logic [VW-1:0] imp_var;

  logic [RW-1:0] cmem [256];
  logic [VW:0]   exp_q [$];
  int checks = 0, failures = 0, pops = 0, en_cnt = 0, done_cnt = 0;

  bcp_clause_feeder dut (
    .clk(clk), .rst(rst), .start(start), .num_clauses(num_clauses),
    .asg_def(asg_def), .asg_val(asg_val), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .clause(clause), .clause_type(clause_type),
    .clause_odd(clause_odd), .unit_clause(unit_clause), .imp_valid(imp_valid),
    .imp_ready(imp_ready), .imp_var(imp_var), .imp_val(imp_val), .busy(busy),
    .done(done), .conflict(conflict), .conflict_clause(conflict_clause)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Checker: unit when no literal is true and exactly one is unassigned.
  function automatic logic [3:0] chk_unit(input logic [7:0] c, input logic [7:0] t, input logic [3:0] o);
    int sz, nun; bit sat; logic [3:0] u;
    sz = int'(t[7:6]) + 1; nun = 0; sat = 0; u = '0;
    for (int i = 0; i < sz; i++) begin
      if (!o[i]) begin nun++; u = 4'(1 << i); end
      else if (c[2*i] == t[i]) sat = 1;
    end
    return (!sat && nun == 1) ? u : 4'h0;
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= cmem[mem_addr];
  always @(posedge clk) unit_clause <= chk_unit(clause, clause_type, clause_odd);

  function automatic logic [RW-1:0] mk(input int size, input logic [3:0] pol,
                                       input logic [VW-1:0] v0, v1, v2, v3);
    return {2'(size - 1), pol, v3, v2, v1, v0};
  endfunction

  // Expected result of a clause word against the current assignment.
  function automatic void exp_fn(input logic [RW-1:0] w, output bit unit, output bit conf,
                                 output logic [VW:0] imp);
    int sz, nun; bit sat; logic [3:0] pol; logic [VW-1:0] v;
    sz = int'(w[RW-1 -: 2]) + 1; pol = w[4*VW +: 4]; nun = 0; sat = 0; imp = '0;
    for (int i = 0; i < sz; i++) begin
      v = w[i*VW +: VW];
      if (!asg_def[v]) begin nun++; imp = {v, pol[i]}; end
      else if (asg_val[v] == pol[i]) sat = 1;
    end
    unit = !sat && nun == 1;
    conf = !sat && nun == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (mem_en === 1'b1) en_cnt++;
    if (done === 1'b1) done_cnt++;
    if (imp_valid === 1'b1 && imp_ready) begin
      pops++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL imp_unexpected observed=%0h expected=none", {imp_var, imp_val});
      end
      if (exp_q.size() != 0) chk("imp_entry", 32'({imp_var, imp_val}), 32'(exp_q.pop_front()));
    end
  end

  task automatic launch(input int n);
    bit u, c; logic [VW:0] e;
    for (int k = 0; k < n; k++) begin
      exp_fn(cmem[k], u, c, e);
      if (c) break;
      if (u) exp_q.push_back(e);
    end
    num_clauses = n[AW:0];
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic finish_scan(input int budget, input bit exp_conf, input logic [AW-1:0] exp_cc);
    int i = 0;
    while (!done && i < budget) begin tick(1); i++; end
    chk("done_seen", 32'(done), 32'd1);
    chk("conflict", 32'(conflict), 32'(exp_conf));
    if (exp_conf) chk("conflict_clause", 32'(conflict_clause), 32'(exp_cc));
    tick(1);
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    tick(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int i, e0, p0, d0;
    for (int k = 0; k < 256; k++) cmem[k] = '0;
    tick(2);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_clause", 32'(clause), 0);
    chk("rst_type", 32'(clause_type), 32'hC0);
    chk("rst_odd", 32'(clause_odd), 32'hF);
    chk("rst_imp_valid", 32'(imp_valid), 0);
    chk("rst_busy_done", 32'({busy, done, conflict}), 0);
    chk("rst_conflict_clause", 32'(conflict_clause), 0);
    rst = 1'b0; tick(1);

    // 1: size-4 clause, three false literals and x3 free -> implies x3=1
    asg_def = 16'h0007; asg_val = '0;
    cmem[0] = mk(4, 4'hF, 0, 1, 2, 3);
    launch(1);
    i = 0;
    while (clause_odd === 4'hF && i < 10) begin tick(1); i++; end
    chk("t1_odd", 32'(clause_odd), 32'b0111);
    chk("t1_clause", 32'(clause), 32'h2A);
    chk("t1_type", 32'(clause_type), 32'hCF);
    finish_scan(50, 0, 0);

    // 2: size-1 clause on free x5, negative literal; done waits for the pop
    asg_def = '0;
    cmem[0] = mk(1, 4'b0000, 5, 0, 0, 0);
    imp_ready = 1'b0; d0 = done_cnt;
    launch(1);
    tick(10);
    chk("t2_busy_held", 32'(busy), 1);
    chk("t2_imp_valid", 32'(imp_valid), 1);
    chk("t2_no_done", 32'(done_cnt - d0), 0);
    imp_ready = 1'b1;
    finish_scan(20, 0, 0);

    // 3: ten unit clauses under backpressure; issue stops at the FIFO credit limit
    for (int k = 0; k < 10; k++) cmem[k] = mk(1, {3'b000, k[0]}, k[3:0], 0, 0, 0);
    imp_ready = 1'b0; e0 = en_cnt;
    launch(10);
    tick(30);
    chk("t3_issued_stalled", 32'(en_cnt - e0), 4);
    chk("t3_mem_en_low", 32'(mem_en), 0);
    chk("t3_busy", 32'(busy), 1);
    p0 = pops; imp_ready = 1'b1;
    finish_scan(300, 0, 0);
    chk("t3_all_popped", 32'(pops - p0), 10);
    chk("t3_all_issued", 32'(en_cnt - e0), 10);

    // 4: clause 6 has every literal false; later units must never appear
    asg_def = 16'h0F00; asg_val = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 6)         cmem[k] = mk(2, 4'b0011, 8, 9, 0, 0);
      else if (k > 6)     cmem[k] = mk(1, 4'b0001, 4'(k + 5), 0, 0, 0);
      else if (k[0] == 0) cmem[k] = mk(1, 4'b0001, k[3:0], 0, 0, 0);
      else                cmem[k] = mk(2, 4'b0000, 8, k[3:0], 0, 0);
    end
    launch(10);
    finish_scan(200, 1, 6);
    chk("t4_conflict_held", 32'(conflict), 1);
    chk("t4_imp_valid", 32'(imp_valid), 0);

    // 5: empty scan, then a start pulse while busy is ignored
    asg_def = '0; e0 = en_cnt;
    launch(0);
    chk("t5_done_next", 32'(done), 1);
    chk("t5_conflict_cleared", 32'(conflict), 0);
    tick(1);
    chk("t5_done_off", 32'(done), 0);
    chk("t5_no_mem_en", 32'(en_cnt - e0), 0);
    cmem[0] = mk(1, 4'b0001, 1, 0, 0, 0);
    cmem[1] = mk(1, 4'b0000, 2, 0, 0, 0);
    e0 = en_cnt; d0 = done_cnt;
    launch(2);
    num_clauses = 9'd5; start = 1'b1; tick(1); start = 1'b0;
    finish_scan(50, 0, 0);
    chk("t5_issue_count", 32'(en_cnt - e0), 2);
    chk("t5_one_done", 32'(done_cnt - d0), 1);

    // 6: reset in the middle of a scan
    for (int k = 0; k < 10; k++) cmem[k] = mk(1, 4'b0001, k[3:0], 0, 0, 0);
    imp_ready = 1'b0;
    launch(10);
    tick(5);
    d0 = done_cnt;
    rst = 1'b1; tick(1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_imp_valid", 32'(imp_valid), 0);
    chk("t6_type", 32'(clause_type), 32'hC0);
    chk("t6_mem_en", 32'(mem_en), 0);
    rst = 1'b0; exp_q.delete(); imp_ready = 1'b1;
    tick(10);
    chk("t6_no_done", 32'(done_cnt - d0), 0);
    chk("t6_idle", 32'({busy, imp_valid}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
